// File: rtl/cnt_enable_ctrl.sv
// cnt_enable_ctrl
//   Upstream control stage for an n-bit counter. A raw push-button and a raw
//   run switch become the counter's count enable. Two modes are supported:
//   single-step, with one cnt pulse per debounced press, and free-run, with
//   cnt held high. Free-run can halt on the counter's carry-out.
//
// Parameters
//   DB_CNT      consecutive cycles a synchronized btn level must differ from
//               the debounced level before the debounced level flips (>=2)
//   REPEAT_DLY  cycles between auto-repeat step pulses while btn is held
//               (only with AUTO_REPEAT_EN; >=2)
//
// Ports
//   clock       single clock, all logic on the rising edge
//   reset       synchronous, active-high; clears all state
//   btn         raw asynchronous push-button (bouncy)
//   run         raw asynchronous run switch (level)
//   stop_on_co  1: free-run halts when co is seen (static, clock-synchronous)
//   co          carry-out fed back from the counter
//   cnt         registered count enable to the counter
//   halted      registered, 1 while the controller sits in HALT
//
// Configuration macro
//   AUTO_REPEAT_EN  when defined, a held button re-triggers a step pulse
//                   every REPEAT_DLY+1 cycles after the first one.
module cnt_enable_ctrl #(
  parameter int DB_CNT     = 16,
  parameter int REPEAT_DLY = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  input  logic run,
  input  logic stop_on_co,
  input  logic co,
  output logic cnt,
  output logic halted
);

  localparam int DBW = $clog2(DB_CNT);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    WAIT_REL,
    RUN,
    HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic btn_m;
  logic btn_s;
  logic run_m;
  logic run_s;

  logic           btn_db;
  logic           btn_db_prev;
  logic [DBW-1:0] db_c;
  logic           btn_rise;

  logic cnt_nxt;
  logic halted_nxt;

  // Two-flop synchronizers for both asynchronous inputs. The run switch is
  // a clean level, so it is only synchronized, not debounced.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      run_m <= 1'b0;
      run_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      run_m <= run;
      run_s <= run_m;
    end
  end

  // Debouncer: db_c counts consecutive cycles where the synchronized button
  // disagrees with the debounced level. Any agreeing cycle restarts the count,
  // so a glitch shorter than DB_CNT cycles never reaches btn_db.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_db <= 1'b0;
      db_c   <= '0;
    end else if (btn_s == btn_db) begin
      db_c <= '0;
    end else if (db_c == DB_LAST) begin
      btn_db <= btn_s;
      db_c   <= '0;
    end else begin
      db_c <= db_c + DBW'(1);
    end
  end

  // Previous debounced level, used to find the press (rising) edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_db_prev <= 1'b0;
    end else begin
      btn_db_prev <= btn_db;
    end
  end

  assign btn_rise = btn_db & ~btn_db_prev;

`ifdef AUTO_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_DLY);
  localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_DLY - 1);

  logic [RPW-1:0] rp_c;
  logic           rp_done;

  assign rp_done = (rp_c == RP_LAST);

  // Repeat timer only advances while waiting for release. Holding it at zero
  // everywhere else means it always starts from zero on WAIT_REL entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      rp_c <= '0;
    end else if ((state == WAIT_REL) && !rp_done) begin
      rp_c <= rp_c + RPW'(1);
    end else begin
      rp_c <= '0;
    end
  end
`endif

  // Next-state and next-output logic. Outputs are decoded from the next
  // state so cnt/halted are registered alongside the state itself.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = 1'b0;
    halted_nxt = 1'b0;
    case (state)
      IDLE: begin
        // A same-cycle run request beats a button press.
        if (run_s) begin
          state_nxt = RUN;
        end else if (btn_rise) begin
          state_nxt = STEP;
        end
      end
      STEP: begin
        state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        // run is deliberately ignored until the button is released.
        if (!btn_db) begin
          state_nxt = IDLE;
`ifdef AUTO_REPEAT_EN
        end else if (rp_done) begin
          state_nxt = STEP;
`endif
        end
      end
      RUN: begin
        // Dropping run wins over a simultaneous carry-out. On a halt the
        // counter wraps on the same edge, leaving it parked at zero.
        if (!run_s) begin
          state_nxt = IDLE;
        end else if (stop_on_co && co) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        if (!run_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    cnt_nxt    = (state_nxt == STEP) || (state_nxt == RUN);
    halted_nxt = (state_nxt == HALT);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      halted <= halted_nxt;
    end
  end

endmodule
